seq_det_scheduler: RTL
======================

Name: seq_det_scheduler

Overview:
- Shares one overlapping serial pattern detector (default 10110) between NREQ serial requesters.
- Round-robin arbiter grants one requester per frame and clears the detector before each frame.
- Feeds exactly FRAME_LEN accepted bits from the granted requester, counts overlapping matches, then reports the count and requester id with a one-cycle done pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PATTERN, 5'b10110, pattern to detect; MSB is the first bit received.
- PLEN, 5, pattern length in bits.
- FRAME_LEN, 16, accepted bits per frame (>= PLEN).
- CNT_W, 5, match counter width; must hold FRAME_LEN-PLEN+1.
- TIMEOUT, 8, idle-bit watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester frame request; level, held for the whole frame.
- bit_valid  in  NREQ  per-requester serial bit valid.
- bit_data  in  NREQ  per-requester serial bit.
- grant  out  NREQ  one-hot grant, registered; doubles as bit ready.
- det_out  out  1  registered Moore match flag; high for the cycle after the bit completing a match.
- done  out  1  one-cycle frame-complete pulse.
- done_id  out  $clog2(NREQ)  requester index of the reported frame.
- match_cnt  out  CNT_W  matches in the reported frame; holds its value until the next done.
- aborted  out  1  qualifies done: the frame ended early.

Behaviour:
- Reset: async and active-high. FSM goes to IDLE. Outputs grant=0, det_out=0, done=0, done_id=0, match_cnt=0, aborted=0. Round-robin pointer (last granted id) = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, BUSY, REPORT.
- IDLE:
  - If any req bit is set, select the first set bit searching from last+1 (modulo NREQ).
  - Next cycle: grant is one-hot on the winner, the bit counter and match counter are cleared, the detector is cleared (shift register and fill count zeroed), state goes to BUSY, and last is updated.
  - Grant latency is 1 cycle after req is sampled.
- BUSY:
  - A bit is accepted when grant[i] & bit_valid[i].
  - Each accepted bit shifts into a PLEN-bit register and saturates a fill counter at PLEN.
  - hit = accept & (next shift value == PATTERN) & (next fill == PLEN).
  - On hit, the match counter increments (saturates at all-ones); det_out is 1 on the next cycle and 0 otherwise.
  - Overlap is inherent: the shift register is not cleared after a hit.
  - The bit counter increments on each accept. On the accept of bit FRAME_LEN, state goes to REPORT.
  - If req[granted] drops before FRAME_LEN bits are accepted, state goes to REPORT with abort set. A bit accepted in the same cycle the req drops is still counted.
- REPORT (1 cycle):
  - done=1, done_id=granted id, match_cnt=final count, aborted=abort flag.
  - grant=0, abort flag cleared, next state IDLE.
  - The same requester may be re-granted only after all others have been checked (round-robin).
- Bits presented by non-granted requesters are ignored.
- bit_valid in IDLE or REPORT is ignored.
- Reset asserted mid-frame: the frame is discarded with no done pulse.
- A new req arriving during REPORT is considered in the following IDLE cycle; the minimum gap between frames is 2 cycles.

Optional Feature:
- Macro: SEQ_SCHED_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in BUSY and resets on every accept.
  - If it reaches TIMEOUT cycles with no accept, state goes to REPORT with aborted=1, using the partial match count.
- When undefined:
  - No watchdog; BUSY waits indefinitely for bits while req is held.
  - The TIMEOUT parameter is unused.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum typedef (IDLE, BUSY, REPORT);
  - the default PATTERN/PLEN constants;
  - the function that computes the next round-robin winner.
- Sub-module seq_det_core: the shift-register matcher.
  - Inputs: clk, rst, clr, en, din.
  - Outputs: hit (combinational strobe), det_out (registered).

Test Plan:
- req=4'b0001; requester 0 sends 1011011000000000 -> grant=0001 one cycle after req; det_out pulses after bits 5 and 8; done with done_id=0, match_cnt=2, aborted=0.
- req=4'b1010 held from reset -> grants in order 0010, 1000, 0010 across three frames; each done_id matches the grant.
- Frame from requester 2 with bit_valid toggling every other cycle, data 1011010110 followed by zeros -> match_cnt=2; done occurs exactly after accepted bit 16.
- Requester 1 drops req after 7 accepted bits (1011010) -> done, aborted=1, match_cnt=1, grant returns to 0.
- rst asserted mid-frame after 9 bits -> all outputs 0 immediately (asynchronous); no done; next frame's match_cnt is not polluted by earlier bits.
- With SEQ_SCHED_TIMEOUT_EN defined: after 3 accepted bits, bit_valid=0 for 8 cycles -> done, aborted=1, match_cnt=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and helpers for the serial pattern-detector
//               scheduler: FSM state encoding, default pattern constants
//               and the round-robin winner function.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int         DEF_PLEN    = 5;
  localparam logic [4:0] DEF_PATTERN = 5'b10110;
  localparam int         MAX_REQ     = 8;

  // First set request strictly after last_id, wrapping modulo nreq.
  // Returns last_id unchanged when no request is set (caller gates on |req).
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last_id,
                                         input int                 nreq);
    logic [2:0] win;
    logic       found;
    int         idx;
    logic [2:0] idx3;
    win   = last_id;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= nreq) begin
        idx  = (int'(last_id) + i) % nreq;
        idx3 = 3'(idx);
        if (!found && req[idx3]) begin
          win   = idx3;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_core
// Description : Overlapping shift-register pattern matcher. The first bit
//               received ends up in the MSB of the window.
// Ports       : clk, rst      - clock, async active-high reset
//               clr_i         - synchronous clear of window, fill and flag
//               en_i / din_i  - bit accept strobe and serial bit
//               hit_o         - combinational: this accepted bit completes
//                               a match
//               det_out_o     - registered match flag (cycle after hit)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic din_i,
  output logic hit_o,
  output logic det_out_o
);

  localparam int FW = $clog2(PLEN + 1);

  logic [PLEN-1:0] shift_q, shift_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            det_q;

  // Fill count keeps a partially loaded window from matching stale zeros.
  always_comb begin
    shift_d = {shift_q[PLEN-2:0], din_i};
    fill_d  = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);
  end

  assign hit_o     = en_i & (shift_d == PATTERN) & (fill_d == FW'(PLEN));
  assign det_out_o = det_q;

  // Window is never cleared on a hit, so overlapping matches are counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
    end else if (clr_i) begin
      shift_q <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      det_q <= hit_o;
      if (en_i) begin
        shift_q <= shift_d;
        fill_q  <= fill_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_scheduler
// Description : Round-robin shares one serial pattern detector among NREQ
//               requesters. Each granted frame feeds FRAME_LEN accepted
//               bits, counts overlapping matches and reports the count with
//               a one-cycle done pulse.
// Build macro : SEQ_SCHED_TIMEOUT_EN - enables an idle-bit watchdog that
//               aborts a frame after TIMEOUT cycles without an accept.
// Ports       : clk, rst         - clock, async active-high reset
//               req_i[NREQ]      - per-requester frame request (level)
//               bit_valid_i/bit_data_i[NREQ] - per-requester serial bits
//               grant_o[NREQ]    - registered one-hot grant / bit ready
//               det_out_o        - registered match flag
//               done_o           - one-cycle frame-complete pulse
//               done_id_o        - requester of the reported frame
//               match_cnt_o      - match count, held until next done
//               aborted_o        - qualifies done: frame ended early
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int              NREQ      = 4,
  parameter int              PLEN      = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN   = DEF_PATTERN,
  parameter int              FRAME_LEN = 16,
  parameter int              CNT_W     = 5,
  parameter int              TIMEOUT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         bit_valid_i,
  input  logic [NREQ-1:0]         bit_data_i,
  output logic [NREQ-1:0]         grant_o,
  output logic                    det_out_o,
  output logic                    done_o,
  output logic [$clog2(NREQ)-1:0] done_id_o,
  output logic [CNT_W-1:0]        match_cnt_o,
  output logic                    aborted_o
);

  localparam int ID_W = $clog2(NREQ);
  localparam int BCW  = $clog2(FRAME_LEN + 1);

  if ((NREQ < 2) || (NREQ > MAX_REQ) || (FRAME_LEN < PLEN) || (TIMEOUT < 1))
  begin : g_param_check
    $error("seq_det_scheduler: illegal parameter combination");
  end

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q;
  logic [ID_W-1:0]   last_q;      // last granted id; also the active frame's id
  logic [BCW-1:0]    bit_cnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              abort_q;
  logic [ID_W-1:0]   rep_id_q;
  logic [CNT_W-1:0]  rep_cnt_q;

  logic              w_any_req, w_accept, w_din, w_hit, w_last_bit;
  logic              w_req_lost, w_timeout, w_end, w_abort, w_start;
  logic [ID_W-1:0]   w_win;
  logic [CNT_W-1:0]  w_cnt_next;

  assign w_any_req  = |req_i;
  assign w_win      = ID_W'(rr_next(8'(req_i), 3'(last_q), NREQ));
  assign w_start    = (state_q == ST_IDLE) & w_any_req;
  // grant_q is only non-zero in BUSY, so it also masks non-granted bits.
  assign w_accept   = (state_q == ST_BUSY) & |(grant_q & bit_valid_i);
  assign w_din      = |(grant_q & bit_data_i);
  assign w_last_bit = w_accept & (bit_cnt_q == BCW'(FRAME_LEN - 1));
  assign w_req_lost = ~|(grant_q & req_i);
  assign w_end      = w_last_bit | w_req_lost | w_timeout;
  // A final bit accepted as req drops still completes the frame normally.
  assign w_abort    = ~w_last_bit & (w_req_lost | w_timeout);
  assign w_cnt_next = (w_hit && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef SEQ_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q;

  assign w_timeout = ~w_accept & (wd_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if ((state_q != ST_BUSY) || w_accept) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WDW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  seq_det_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_start),
    .en_i      (w_accept),
    .din_i     (w_din),
    .hit_o     (w_hit),
    .det_out_o (det_out_o)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_any_req) state_d = ST_BUSY;
      ST_BUSY:   if (w_end)     state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    done_o      = (state_q == ST_REPORT);
    aborted_o   = (state_q == ST_REPORT) & abort_q;
    done_id_o   = rep_id_q;
    match_cnt_o = rep_cnt_q;
    grant_o     = grant_q;
  end

  // Frame datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      last_q    <= ID_W'(NREQ - 1);
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      rep_id_q  <= '0;
      rep_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any_req) begin
            grant_q   <= NREQ'(1) << w_win;
            last_q    <= w_win;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
          end
        end
        ST_BUSY: begin
          cnt_q <= w_cnt_next;
          if (w_accept) bit_cnt_q <= bit_cnt_q + BCW'(1);
          if (w_end) begin
            grant_q   <= '0;
            rep_id_q  <= last_q;
            rep_cnt_q <= w_cnt_next;
            abort_q   <= w_abort;
          end
        end
        default: begin
          abort_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
